// File: rtl/se_blend_select.sv
// se_blend_select
//   Per-pixel stage feeding the per-channel blend units. For each pixel it
//   resolves the top and second visible layers among BG0-3, OBJ and the
//   backdrop. It then decides the colour special effect from the
//   scanline-latched BLDCNT/BLDALPHA/BLDY copies, the window effect enable
//   and OBJ semi-transparency.
//
//   Pipeline: stage A registers the resolved layers (_p1). Stage B registers
//   the effect decision into the output registers (_p2). A whole-pipe stall
//   holds both stages while the output is valid and not accepted.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   line_start            scanline pulse; latches bldcnt/bldalpha/bldy shadows
//   bldcnt/bldalpha/bldy  live blend registers
//   in_valid/in_ready     upstream handshake for one candidate set
//   layer_color/opaque/prio  per-layer candidates (0-3 BG, 4 OBJ, 5 backdrop)
//   obj_semi, effect_en   OBJ semi-transparent flag, window effect enable
//   out_valid/out_ready   downstream handshake
//   first_color, second_color, control, alpha, y  blend unit operands
module se_blend_select #(
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             line_start,
  input  logic [15:0]      bldcnt,
  input  logic [15:0]      bldalpha,
  input  logic [15:0]      bldy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0][14:0] layer_color,
  input  logic [5:0]       layer_opaque,
  input  logic [5:0][1:0]  layer_prio,
  input  logic             obj_semi,
  input  logic             effect_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      first_color,
  output logic [14:0]      second_color,
  output logic [1:0]       control,
  output logic [15:0]      alpha,
  output logic [15:0]      y
);

  localparam logic [2:0]  BackdropId = 3'd5;
  localparam logic [15:0] AlphaNone  = 16'h0010;

  // Coefficients above 16 saturate to 16 (full weight).
  function automatic logic [4:0] sat16(input logic [4:0] v);
    return (v > 5'd16) ? 5'd16 : v;
  endfunction

  // Tie-break rank within one priority level: OBJ first, then BG0..BG3.
  function automatic logic [2:0] tie_rank(input int idx);
    return (idx == 4) ? 3'd0 : 3'(idx + 1);
  endfunction

  logic [15:0] bldcnt_sh_q, alpha_sh_q, y_sh_q;
  logic [LATENCY-1:0] vld_q;
  logic        stall;

  logic [2:0]  top_id_d, sec_id_d;
  logic [5:0]  top_key, sec_key, key_c;

  logic [2:0]  top_id_p1_q, sec_id_p1_q;
  logic [14:0] top_col_p1_q, sec_col_p1_q;
  logic        semi_p1_q, eff_p1_q;

  logic [5:0]  first_en, second_en;
  logic [1:0]  mode;
  logic        ft, st;
  logic [1:0]  ctrl_d;
  logic [14:0] second_d;
  logic [15:0] alpha_d, y_d;

  logic [14:0] first_p2_q, second_p2_q;
  logic [1:0]  ctrl_p2_q;
  logic [15:0] alpha_p2_q, y_p2_q;

  assign stall     = vld_q[LATENCY-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[LATENCY-1];

  // Shadows update independently of the pipe; stage B reads the registered
  // copy, so a pixel moving through stage B on the load edge sees old values.
  always_ff @(posedge clock) begin
    if (reset) begin
      bldcnt_sh_q <= '0;
      alpha_sh_q  <= '0;
      y_sh_q      <= '0;
    end else if (line_start) begin
      bldcnt_sh_q <= bldcnt;
      alpha_sh_q  <= {3'b0, sat16(bldalpha[12:8]), 3'b0, sat16(bldalpha[4:0])};
      y_sh_q      <= {11'b0, sat16(bldy[4:0])};
    end
  end

  // Layer resolution: key = {prio, tie rank}; smaller wins. The backdrop
  // starts as the incumbent with the maximal key so any opaque layer beats it.
  always_comb begin
    top_id_d = BackdropId;
    top_key  = 6'h3F;
    sec_id_d = BackdropId;
    sec_key  = 6'h3F;
    key_c    = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      key_c = {1'b0, layer_prio[i], tie_rank(i)};
      if (layer_opaque[i] && key_c < top_key) begin
        top_key  = key_c;
        top_id_d = 3'(i);
      end
    end
    for (int i = 0; i < 5; i++) begin
      key_c = {1'b0, layer_prio[i], tie_rank(i)};
      if (layer_opaque[i] && 3'(i) != top_id_d && key_c < sec_key) begin
        sec_key  = key_c;
        sec_id_d = 3'(i);
      end
    end
  end

  // Stage A -> p1: resolved layer ids and colours
  always_ff @(posedge clock) begin
    if (!stall) begin
      top_id_p1_q  <= top_id_d;
      sec_id_p1_q  <= sec_id_d;
      top_col_p1_q <= layer_color[top_id_d];
      sec_col_p1_q <= layer_color[sec_id_d];
      semi_p1_q    <= obj_semi;
      eff_p1_q     <= effect_en;
    end
  end

  // Effect decision from p1 and the shadows
  assign first_en  = bldcnt_sh_q[5:0];
  assign second_en = bldcnt_sh_q[13:8];
  assign mode      = bldcnt_sh_q[7:6];
  assign ft        = first_en[top_id_p1_q];
  // Backdrop-only pixels have no distinct second layer to blend with.
  assign st        = (sec_id_p1_q == top_id_p1_q) ? 1'b0 : second_en[sec_id_p1_q];

  always_comb begin
    ctrl_d   = 2'b00;
    second_d = '0;
    alpha_d  = AlphaNone;
    y_d      = '0;
    if (!eff_p1_q) begin
      ctrl_d = 2'b00;
    end else if ((top_id_p1_q == 3'd4 && semi_p1_q && st) ||
                 (mode == 2'b01 && ft && st)) begin
      ctrl_d   = 2'b01;
      second_d = sec_col_p1_q;
      alpha_d  = alpha_sh_q;
    end else if (mode[1] && ft) begin
      ctrl_d = mode;
      y_d    = y_sh_q;
    end
  end

  // Stage B -> p2: output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q       <= '0;
      first_p2_q  <= '0;
      second_p2_q <= '0;
      ctrl_p2_q   <= '0;
      alpha_p2_q  <= '0;
      y_p2_q      <= '0;
    end else if (!stall) begin
      vld_q       <= {vld_q[LATENCY-2:0], in_valid};
      first_p2_q  <= top_col_p1_q;
      second_p2_q <= second_d;
      ctrl_p2_q   <= ctrl_d;
      alpha_p2_q  <= alpha_d;
      y_p2_q      <= y_d;
    end
  end

  assign first_color  = first_p2_q;
  assign second_color = second_p2_q;
  assign control      = ctrl_p2_q;
  assign alpha        = alpha_p2_q;
  assign y            = y_p2_q;

endmodule

// File: tb/tb_se_blend_select.sv
`timescale 1ns/1ps
module tb_se_blend_select;

  logic             clock = 1'b0;
  logic             reset;
  logic             line_start;
  logic [15:0]      bldcnt, bldalpha, bldy;
  logic             in_valid;
  logic             in_ready;
  logic [5:0][14:0] layer_color;
  logic [5:0]       layer_opaque;
  logic [5:0][1:0]  layer_prio;
  logic             obj_semi, effect_en;
  logic             out_valid, out_ready;
  logic [14:0]      first_color, second_color;
  logic [1:0]       control;
  logic [15:0]      alpha, y;

  int n_cmp = 0;
  int n_bad = 0;

  se_blend_select #(.LATENCY(2)) dut (
    .clock(clock), .reset(reset), .line_start(line_start),
    .bldcnt(bldcnt), .bldalpha(bldalpha), .bldy(bldy),
    .in_valid(in_valid), .in_ready(in_ready),
    .layer_color(layer_color), .layer_opaque(layer_opaque), .layer_prio(layer_prio),
    .obj_semi(obj_semi), .effect_en(effect_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .first_color(first_color), .second_color(second_color),
    .control(control), .alpha(alpha), .y(y)
  );

  always #5 clock = ~clock;

  task automatic clear_layers();
    layer_color  = '0;
    layer_opaque = '0;
    layer_prio   = '0;
    obj_semi     = 1'b0;
    effect_en    = 1'b1;
  endtask

  task automatic set_layer(input int i, input logic [14:0] col, input logic [1:0] p);
    layer_color[i]  = col;
    layer_opaque[i] = 1'b1;
    layer_prio[i]   = p;
  endtask

  task automatic load_shadow(input logic [15:0] c, input logic [15:0] a, input logic [15:0] yy);
    @(negedge clock);
    bldcnt = c; bldalpha = a; bldy = yy; line_start = 1'b1;
    @(negedge clock);
    line_start = 1'b0;
  endtask

  // One pixel; returns at the negedge where its result should be valid.
  task automatic push();
    @(negedge clock); in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    @(negedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    n_cmp++; if ({first_color, second_color, control, alpha, y} !== 64'h0) begin n_bad++;
      $display("FAIL rst_data: got %h/%h/%b/%h/%h want all zero", first_color, second_color, control, alpha, y); end
  endtask

  task automatic test_no_effect();
    load_shadow(16'h0000, 16'h0000, 16'h0000);
    clear_layers();
    set_layer(2, 15'h7FFF, 2'd1);
    @(negedge clock); in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early: got %b want 0", out_valid); end
    @(negedge clock); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_2: got %b want 1", out_valid); end
    n_cmp++; if (first_color !== 15'h7FFF) begin n_bad++; $display("FAIL ne_first: got %h want 7fff", first_color); end
    n_cmp++; if (second_color !== 15'h0) begin n_bad++; $display("FAIL ne_second: got %h want 0", second_color); end
    n_cmp++; if (control !== 2'b00) begin n_bad++; $display("FAIL ne_ctrl: got %b want 00", control); end
    n_cmp++; if (alpha !== 16'h0010 || y !== 16'h0) begin n_bad++; $display("FAIL ne_alpha_y: got %h/%h want 0010/0000", alpha, y); end
    @(negedge clock); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bubble: got %b want 0", out_valid); end
  endtask

  task automatic test_alpha();
    load_shadow(16'h0241, 16'h0A06, 16'h0000);
    clear_layers();
    set_layer(0, 15'h001F, 2'd0);
    set_layer(1, 15'h03E0, 2'd2);
    push();
    n_cmp++; if (control !== 2'b01) begin n_bad++; $display("FAIL al_ctrl: got %b want 01", control); end
    n_cmp++; if (alpha !== 16'h0A06) begin n_bad++; $display("FAIL al_alpha: got %h want 0a06", alpha); end
    n_cmp++; if (first_color !== 15'h001F || second_color !== 15'h03E0) begin n_bad++;
      $display("FAIL al_colors: got %h/%h want 001f/03e0", first_color, second_color); end
    // EVA=20, EVB=31 both saturate to 16
    load_shadow(16'h0241, 16'h1F14, 16'h0000);
    push();
    n_cmp++; if (alpha !== 16'h1010) begin n_bad++; $display("FAIL al_clamp: got %h want 1010", alpha); end
    // BG1 and BG3 tie at prio 0: BG1 is top, BG3 second
    load_shadow(16'h0842, 16'h0804, 16'h0000);
    clear_layers();
    set_layer(3, 15'h0333, 2'd0);
    set_layer(1, 15'h0111, 2'd0);
    set_layer(2, 15'h0222, 2'd3);
    push();
    n_cmp++; if (first_color !== 15'h0111 || second_color !== 15'h0333 || control !== 2'b01) begin n_bad++;
      $display("FAIL bg_tie: got %h/%h/%b want 0111/0333/01", first_color, second_color, control); end
  endtask

  task automatic test_bright();
    load_shadow(16'h0081, 16'h0A06, 16'h0014);
    clear_layers();
    set_layer(0, 15'h1111, 2'd0);
    set_layer(1, 15'h2222, 2'd1);
    push();
    n_cmp++; if (control !== 2'b10 || y !== 16'h0010) begin n_bad++; $display("FAIL br_up: got %b/%h want 10/0010", control, y); end
    n_cmp++; if (second_color !== 15'h0 || alpha !== 16'h0010) begin n_bad++;
      $display("FAIL br_enc: got %h/%h want 0000/0010", second_color, alpha); end
    load_shadow(16'h00C1, 16'h0000, 16'h0007);
    push();
    n_cmp++; if (control !== 2'b11 || y !== 16'h0007 || first_color !== 15'h1111) begin n_bad++;
      $display("FAIL br_down: got %b/%h/%h want 11/0007/1111", control, y, first_color); end
  endtask

  task automatic test_backdrop();
    clear_layers();
    layer_color[5] = 15'h4210;
    load_shadow(16'h2060, 16'h0804, 16'h0000);
    push();
    n_cmp++; if (first_color !== 15'h4210 || second_color !== 15'h0 || control !== 2'b00) begin n_bad++;
      $display("FAIL bd_alpha: got %h/%h/%b want 4210/0000/00", first_color, second_color, control); end
    load_shadow(16'h00A0, 16'h0000, 16'h0003);
    push();
    n_cmp++; if (control !== 2'b10 || y !== 16'h0003) begin n_bad++; $display("FAIL bd_bright: got %b/%h want 10/0003", control, y); end
  endtask

  task automatic test_obj_semi();
    load_shadow(16'h0200, 16'h0804, 16'h0000);
    clear_layers();
    set_layer(4, 15'h1234, 2'd1);
    set_layer(1, 15'h0555, 2'd1);
    obj_semi = 1'b1;
    push();
    n_cmp++; if (control !== 2'b01 || alpha !== 16'h0804) begin n_bad++; $display("FAIL semi_ctrl: got %b/%h want 01/0804", control, alpha); end
    n_cmp++; if (first_color !== 15'h1234 || second_color !== 15'h0555) begin n_bad++;
      $display("FAIL semi_colors: got %h/%h want 1234/0555", first_color, second_color); end
    effect_en = 1'b0;
    push();
    n_cmp++; if (control !== 2'b00 || alpha !== 16'h0010 || second_color !== 15'h0) begin n_bad++;
      $display("FAIL win_off: got %b/%h/%h want 00/0010/0000", control, alpha, second_color); end
    effect_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    bit prev_stall = 1'b0;
    bit saw_block = 1'b0;
    logic [14:0] prev_col = '0;
    load_shadow(16'h0000, 16'h0000, 16'h0000);
    clear_layers();
    set_layer(0, 15'h0101, 2'd0);
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clock);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      layer_color[0] = 15'h0101 + 15'(sent);
      #1;
      if (cyc == 2) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b want 0", in_ready); end
      end
      if (prev_stall) begin
        n_cmp++; if (out_valid !== 1'b1 || first_color !== prev_col) begin n_bad++;
          $display("FAIL stall_hold: got %b/%h want 1/%h", out_valid, first_color, prev_col); end
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (first_color !== 15'h0101 + 15'(recv)) begin n_bad++;
          $display("FAIL order: got %h want %h", first_color, 15'h0101 + 15'(recv)); end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_col   = first_color;
      if (!in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (recv != 4 || sent != 4 || !saw_block) begin n_bad++;
      $display("FAIL b2b_count: got recv=%0d sent=%0d blocked=%0d want 4/4/1", recv, sent, saw_block); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_line_start();
    load_shadow(16'h0000, 16'h0000, 16'h0000);
    clear_layers();
    set_layer(0, 15'h0AAA, 2'd0);
    @(negedge clock); in_valid = 1'b1;
    @(negedge clock);
    bldcnt = 16'h0081; bldy = 16'h0005; line_start = 1'b1;
    layer_color[0] = 15'h0BBB;
    @(negedge clock); line_start = 1'b0; in_valid = 1'b0; #1;
    n_cmp++; if (first_color !== 15'h0AAA || control !== 2'b00 || y !== 16'h0) begin n_bad++;
      $display("FAIL ls_old: got %h/%b/%h want 0aaa/00/0000", first_color, control, y); end
    @(negedge clock); #1;
    n_cmp++; if (first_color !== 15'h0BBB || control !== 2'b10 || y !== 16'h0005) begin n_bad++;
      $display("FAIL ls_new: got %h/%b/%h want 0bbb/10/0005", first_color, control, y); end
    // Reset with a pixel in flight
    @(negedge clock); in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0; reset = 1'b1;
    @(negedge clock); #1;
    n_cmp++; if (out_valid !== 1'b0 || first_color !== 15'h0) begin n_bad++;
      $display("FAIL mid_rst: got %b/%h want 0/0000", out_valid, first_color); end
    reset = 1'b0;
    push();
    n_cmp++; if (out_valid !== 1'b1 || control !== 2'b00 || alpha !== 16'h0010) begin n_bad++;
      $display("FAIL rst_shadow: got %b/%b/%h want 1/00/0010", out_valid, control, alpha); end
  endtask

  initial begin
    reset = 1'b1; line_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    bldcnt = '0; bldalpha = '0; bldy = '0;
    clear_layers();
    test_reset();
    test_no_effect();
    test_alpha();
    test_bright();
    test_backdrop();
    test_obj_semi();
    test_back_to_back();
    test_line_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
